// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared types and constants for the bit-serial subtractor.
//   state_t   : controller states (IDLE / RUN / DONE)
//   SUB_WIDTH : default operand/result width in bits
package serial_sub_pkg;

   localparam int SUB_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder
//   One-bit full adder.
//   x, y, z : addend bits and carry in
//   s       : sum bit
//   c       : carry out
module full_adder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);

   assign s = x ^ y ^ z;
   assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial A-B, LSB first, one bit per clock, using a single full adder
//   fed with a_lsb + ~b_lsb + carry (carry seeded to 1 for the two's-complement +1).
//   Optional macro SERIAL_SUB_OVF_EN adds output V (signed overflow).
//
//   Ports
//     Clk   : clock, all state on rising edge
//     Reset : synchronous active-high reset
//     Run   : start request, level-sampled in IDLE; must drop in DONE to re-arm
//     A, B  : minuend / subtrahend, captured on start
//     Diff  : A-B mod 2^WIDTH, valid while Done=1
//     BO    : borrow out (A<B unsigned), valid while Done=1
//     Busy  : high in RUN
//     Done  : high in DONE
//     V     : signed overflow, valid while Done=1 (SERIAL_SUB_OVF_EN only)
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Diff,
   output logic             BO,
   output logic             Busy,
   output logic             Done
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             V
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             sum, cout;
   logic             last_bit;

   full_adder u_fa (
      .x (a_sr[0]),
      .y (~b_sr[0]),
      .z (carry),
      .s (sum),
      .c (cout)
   );

   assign last_bit = (cnt == LAST);

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state; DONE waits for Run to drop so a held Run cannot restart
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Run)      state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    if (!Run)     state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

`ifdef SERIAL_SUB_OVF_EN
   // Operand sign bits are shifted out during the run, so keep copies
   logic a_msb_q, b_msb_q, v_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         v_q     <= 1'b0;
      end else if (state == IDLE && Run) begin
         a_msb_q <= A[WIDTH-1];
         b_msb_q <= B[WIDTH-1];
      end else if (state == RUN && last_bit) begin
         // final sum bit is the result sign
         v_q <= (a_msb_q != b_msb_q) && (sum != a_msb_q);
      end
   end

   assign V = v_q;
`endif

   // Datapath
   always_ff @(posedge Clk) begin
      if (Reset) begin
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         BO      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (Run) begin
               a_sr    <= A;
               b_sr    <= B;
               diff_sr <= '0;
               cnt     <= '0;
               carry   <= 1'b1;
            end
            RUN: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               diff_sr <= {sum, diff_sr[WIDTH-1:1]};
               carry   <= cout;
               cnt     <= cnt + CW'(1);
               if (last_bit) BO <= ~cout;
            end
            default: ;
         endcase
      end
   end

   assign Diff = diff_sr;
   assign Busy = (state == RUN);
   assign Done = (state == DONE);

endmodule
